fetch_prefetch_queue: RTL and testbench

//  Next-generation IF stage: PC generator, instruction-memory request port and a

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 49 ++++
 rtl/fetch_prefetch_queue.sv | 91 +++++++++
 tb/tb_fetch_prefetch_queue.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch stage
package fetch_pkg;

  localparam int FETCH_XLEN = 32;
  localparam int FETCH_ILEN = 32;
  localparam logic [FETCH_ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_ILEN-1:0] instr;
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] pc_plus_4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular buffer with first-word fall-through head and flush
module fetch_fifo #(
  parameter type T     = logic [31:0],
  parameter int  DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  T                       push_data,
  output T                       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + (PW+1)'(1);
      else if (!push && pop) count <= count - (PW+1)'(1);
    end
  end

  assign head = mem[rd_ptr];

  // Slots are reserved at issue time, so a full queue can never receive a push.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && !flush && count == FULL));

endmodule

// File: rtl/fetch_prefetch_queue.sv
// rtl/fetch_prefetch_queue.sv - IF stage: PC generator, imem request port, prefetch queue
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN     = FETCH_XLEN,
  parameter int              ILEN     = FETCH_ILEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall_f,
  input  logic                     pc_src_e,
  input  logic [XLEN-1:0]          pc_target_e,
  output logic                     imem_req_o,
  output logic [XLEN-1:0]          imem_addr_o,
  input  logic [ILEN-1:0]          imem_rdata_i,
  output logic                     valid_d_o,
  input  logic                     ready_d_i,
  output logic [ILEN-1:0]          instr_d_o,
  output logic [XLEN-1:0]          pc_d_o,
  output logic [XLEN-1:0]          pc_plus_4_d_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc_f;
  logic [XLEN-1:0] infl_pc;
  logic            inflight;
  logic            issue;
  logic            push;
  logic            pop;
  logic [CW:0]     free;
  logic [CW-1:0]   count;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;
  logic            unused_tgt_bits;

  assign unused_tgt_bits = ^pc_target_e[1:0];

  // A redirect in flight hides the head so decode never consumes a wrong-path entry.
  assign valid_d_o = (count != '0) && !pc_src_e;
  assign pop       = valid_d_o && ready_d_i;
  assign free      = (CW+1)'(DEPTH) + {{CW{1'b0}}, pop}
                   - {1'b0, count} - {{CW{1'b0}}, inflight};
  assign issue     = rst_n && !stall_f && !pc_src_e && (free != '0);
  assign push      = inflight && !pc_src_e;

  assign push_entry.instr     = imem_rdata_i;
  assign push_entry.pc        = infl_pc;
  assign push_entry.pc_plus_4 = infl_pc + XLEN'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f     <= RESET_PC;
      inflight <= 1'b0;
      infl_pc  <= '0;
    end else begin
      inflight <= issue;
      if (pc_src_e) begin
        pc_f <= {pc_target_e[XLEN-1:2], 2'b00};
      end else if (issue) begin
        pc_f    <= pc_f + XLEN'(4);
        infl_pc <= pc_f;
      end
    end
  end

  fetch_fifo #(
    .T     (fetch_entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .flush     (pc_src_e),
    .push_data (push_entry),
    .head      (head),
    .count     (count)
  );

  assign imem_req_o    = issue;
  assign imem_addr_o   = pc_f;
  assign instr_d_o     = head.instr;
  assign pc_d_o        = head.pc;
  assign pc_plus_4_d_o = head.pc_plus_4;
  assign count_o       = count;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb/tb_fetch_prefetch_queue.sv - directed bench for the fetch prefetch queue
module tb_fetch_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_f;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        valid_d;
  logic        ready_d;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc4_d;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  fetch_prefetch_queue #(.XLEN(32), .ILEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_f       (stall_f),
    .pc_src_e      (pc_src_e),
    .pc_target_e   (pc_target_e),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_rdata_i  (imem_rdata),
    .valid_d_o     (valid_d),
    .ready_d_i     (ready_d),
    .instr_d_o     (instr_d),
    .pc_d_o        (pc_d),
    .pc_plus_4_d_o (pc4_d),
    .count_o       (count)
  );

  always #5 clk = ~clk;

  // imem: data for a request appears one cycle later; garbage otherwise
  always @(posedge clk) imem_rdata <= imem_req ? {imem_addr[31:2], 2'b11} : 32'hDEAD_BEEF;

  function automatic logic [31:0] tag(input logic [31:0] a);
    return {a[31:2], 2'b11};
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; stall_f = 1'b0; pc_src_e = 1'b0; pc_target_e = '0; ready_d = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0b exp=0", imem_req); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
    total++; if (valid_d !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", valid_d); end
    total++; if (instr_d !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", instr_d); end
    total++; if (pc_d !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", pc_d); end
    total++; if (pc4_d !== 32'h0) begin bad++; $display("FAIL rst_pc4 got=%h exp=0", pc4_d); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
  endtask

  task automatic test_stream();
    logic [31:0] e;
    logic        ev;
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      if (c != 0) @(negedge clk);
      rst_n = 1'b1; ready_d = 1'b1;
      #1;
      e  = 32'(4 * c);
      ev = (c >= 2);
      total++; if (imem_req !== 1'b1 || imem_addr !== e) begin
        bad++; $display("FAIL stream_req c=%0d got=%0b/%h exp=1/%h", c, imem_req, imem_addr, e); end
      total++; if (valid_d !== ev) begin
        bad++; $display("FAIL stream_valid c=%0d got=%0b exp=%0b", c, valid_d, ev); end
      if (c >= 2) begin
        e = 32'(4 * (c - 2));
        total++; if (pc_d !== e || pc4_d !== e + 32'd4 || instr_d !== tag(e) || count !== 3'd1) begin
          bad++; $display("FAIL stream_head c=%0d got=%h/%h/%h/%0d exp=%h/%h/%h/1",
                          c, pc_d, pc4_d, instr_d, count, e, e + 32'd4, tag(e)); end
      end
    end
  endtask

  task automatic test_full();
    logic [31:0] e;
    apply_reset();
    for (int c = 0; c < 16; c++) begin
      if (c != 0) @(negedge clk);
      rst_n = 1'b1; ready_d = (c >= 10);
      #1;
      if (c >= 4 && c <= 9) begin
        total++; if (imem_req !== 1'b0 || imem_addr !== 32'h10) begin
          bad++; $display("FAIL full_hold c=%0d got=%0b/%h exp=0/00000010", c, imem_req, imem_addr); end
      end
      if (c == 9) begin
        total++; if (count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", count); end
      end
      if (c >= 10) begin
        e = 32'(4 * (c - 10));
        total++; if (valid_d !== 1'b1 || pc_d !== e || instr_d !== tag(e)) begin
          bad++; $display("FAIL full_drain c=%0d got=%0b/%h/%h exp=1/%h/%h", c, valid_d, pc_d, instr_d, e, tag(e)); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 + e) begin
          bad++; $display("FAIL full_resume c=%0d got=%0b/%h exp=1/%h", c, imem_req, imem_addr, 32'h10 + e); end
      end
    end
  endtask

  task automatic test_redirect();
    logic [31:0] e;
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      if (c != 0) @(negedge clk);
      rst_n = 1'b1; ready_d = (c >= 5);
      pc_src_e = (c == 4); pc_target_e = 32'h100;
      #1;
      case (c)
        4: begin
          total++; if (count !== 3'd3 || valid_d !== 1'b0 || imem_req !== 1'b0) begin
            bad++; $display("FAIL redir_n got=%0d/%0b/%0b exp=3/0/0", count, valid_d, imem_req); end
        end
        5, 6: begin
          e = (c == 5) ? 32'h100 : 32'h104;
          total++; if (count !== 3'd0 || valid_d !== 1'b0 || imem_req !== 1'b1 || imem_addr !== e) begin
            bad++; $display("FAIL redir_refetch c=%0d got=%0d/%0b/%0b/%h exp=0/0/1/%h",
                            c, count, valid_d, imem_req, imem_addr, e); end
        end
        7, 8, 9: begin
          e = 32'h100 + 32'(4 * (c - 7));
          total++; if (valid_d !== 1'b1 || pc_d !== e || instr_d !== tag(e)) begin
            bad++; $display("FAIL redir_head c=%0d got=%0b/%h/%h exp=1/%h/%h", c, valid_d, pc_d, instr_d, e, tag(e)); end
        end
        default: ;
      endcase
    end
    pc_src_e = 1'b0;
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      if (c != 0) @(negedge clk);
      rst_n = 1'b1; ready_d = 1'b1;
      pc_src_e = (c == 0 || c == 2);
      pc_target_e = (c == 0) ? 32'h103 : 32'hFFFF_FFFC;
      #1;
      case (c)
        1: begin
          total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            bad++; $display("FAIL wrap_align got=%0b/%h exp=1/00000100", imem_req, imem_addr); end
        end
        3: begin
          total++; if (imem_addr !== 32'hFFFF_FFFC || count !== 3'd0) begin
            bad++; $display("FAIL wrap_top got=%h/%0d exp=fffffffc/0", imem_addr, count); end
        end
        4: begin
          total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            bad++; $display("FAIL wrap_pc got=%0b/%h exp=1/00000000", imem_req, imem_addr); end
        end
        5: begin
          total++; if (valid_d !== 1'b1 || pc_d !== 32'hFFFF_FFFC || pc4_d !== 32'h0 || instr_d !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL wrap_head got=%0b/%h/%h/%h exp=1/fffffffc/00000000/ffffffff",
                            valid_d, pc_d, pc4_d, instr_d); end
        end
        6: begin
          total++; if (pc_d !== 32'h0 || pc4_d !== 32'h4 || instr_d !== 32'h3) begin
            bad++; $display("FAIL wrap_next got=%h/%h/%h exp=00000000/00000004/00000003", pc_d, pc4_d, instr_d); end
        end
        default: ;
      endcase
    end
    pc_src_e = 1'b0;
  endtask

  task automatic test_stall();
    apply_reset();
    for (int c = 0; c < 9; c++) begin
      if (c != 0) @(negedge clk);
      rst_n = 1'b1; ready_d = (c >= 2);
      stall_f = (c == 1 || c == 2 || c == 4 || c == 5);
      pc_src_e = (c == 4); pc_target_e = 32'h200;
      #1;
      case (c)
        1, 4, 5: begin
          total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_noreq c=%0d got=%0b exp=0", c, imem_req); end
        end
        default: ;
      endcase
      case (c)
        2: begin
          total++; if (count !== 3'd1 || valid_d !== 1'b1 || pc_d !== 32'h0 || imem_req !== 1'b0) begin
            bad++; $display("FAIL stall_push got=%0d/%0b/%h/%0b exp=1/1/00000000/0", count, valid_d, pc_d, imem_req); end
        end
        3: begin
          total++; if (count !== 3'd0 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            bad++; $display("FAIL stall_pop got=%0d/%0b/%h exp=0/1/00000004", count, imem_req, imem_addr); end
        end
        5: begin
          total++; if (imem_addr !== 32'h200 || count !== 3'd0) begin
            bad++; $display("FAIL stall_redir got=%h/%0d exp=00000200/0", imem_addr, count); end
        end
        6: begin
          total++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            bad++; $display("FAIL stall_resume got=%0b/%h exp=1/00000200", imem_req, imem_addr); end
        end
        8: begin
          total++; if (valid_d !== 1'b1 || pc_d !== 32'h200 || instr_d !== tag(32'h200)) begin
            bad++; $display("FAIL stall_head got=%0b/%h/%h exp=1/00000200/%h", valid_d, pc_d, instr_d, tag(32'h200)); end
        end
        default: ;
      endcase
    end
    stall_f = 1'b0; pc_src_e = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      if (c != 0) @(negedge clk);
      rst_n = 1'b1; ready_d = 1'b0;
      #1;
    end
    total++; if (count !== 3'd2) begin bad++; $display("FAIL mid_setup got=%0d exp=2", count); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (count !== 3'd0 || valid_d !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h0 ||
                 instr_d !== 32'h0 || pc_d !== 32'h0 || pc4_d !== 32'h0) begin
      bad++; $display("FAIL mid_reset got=%0d/%0b/%0b/%h/%h/%h/%h exp=all zero",
                      count, valid_d, imem_req, imem_addr, instr_d, pc_d, pc4_d); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      rst_n = 1'b1; ready_d = 1'b1;
      #1;
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * c)) begin
        bad++; $display("FAIL mid_restart c=%0d got=%0b/%h exp=1/%h", c, imem_req, imem_addr, 32'(4 * c)); end
    end
    total++; if (valid_d !== 1'b1 || pc_d !== 32'h0 || instr_d !== tag(32'h0) || count !== 3'd1) begin
      bad++; $display("FAIL mid_head got=%0b/%h/%h/%0d exp=1/00000000/%h/1", valid_d, pc_d, instr_d, count, tag(32'h0)); end
  endtask

  initial begin
    rst_n = 1'b0; stall_f = 1'b0; pc_src_e = 1'b0; pc_target_e = '0; ready_d = 1'b0;
    test_reset();
    test_stream();
    test_full();
    test_redirect();
    test_wrap();
    test_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
